// File: rtl/captura_jogada.sv
// Debounces the raw button vector, captures one valid one-hot play and emits
// single-cycle event pulses for the Memory Challenge control unit.
module captura_jogada #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] botoes,
    input  logic         habilita,
    output logic [N-1:0] jogada,
    output logic         jogada_feita,
    output logic         jogada_invalida,
    output logic         ocupado
);

    localparam int            CW         = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_ULTIMO = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        ESTABILIZA,
        CAPTURA,
        ESPERA_SOLTAR
    } estado_t;

    estado_t       estado_q;
    logic [N-1:0]  amostra_q;
    logic [N-1:0]  jogada_q;
    logic [CW-1:0] cnt_q;
    logic          feita_q;
    logic          invalida_q;

    // A value is one-hot when it is nonzero and clearing its lowest set bit leaves zero.
    function automatic logic umQuente(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            amostra_q  <= '0;
            jogada_q   <= '0;
            cnt_q      <= '0;
            feita_q    <= 1'b0;
            invalida_q <= 1'b0;
        end else begin
            feita_q    <= 1'b0;
            invalida_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (habilita && (botoes != '0)) begin
                        amostra_q <= botoes;
                        cnt_q     <= '0;
                        estado_q  <= ESTABILIZA;
                    end
                end
                ESTABILIZA: begin
                    if (!habilita || (botoes == '0)) begin
                        estado_q <= OCIOSO;
                    end else if (botoes != amostra_q) begin
                        amostra_q <= botoes;
                        cnt_q     <= '0;
                    end else if (cnt_q == CNT_ULTIMO) begin
                        estado_q <= CAPTURA;
                        if (umQuente(amostra_q)) begin
                            jogada_q <= amostra_q;
                            feita_q  <= 1'b1;
                        end else begin
                            invalida_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                CAPTURA: begin
                    cnt_q    <= '0;
                    estado_q <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    // Any pressed bit restarts the release count so a held button cannot re-trigger.
                    if (botoes != '0) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_ULTIMO) begin
                        estado_q <= OCIOSO;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign jogada          = jogada_q;
    assign jogada_feita    = feita_q;
    assign jogada_invalida = invalida_q;
    assign ocupado         = (estado_q != OCIOSO);

endmodule

// File: tb/tb_captura_jogada.sv
// Self-checking bench for captura_jogada: vector table, hand-written corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_captura_jogada;

    localparam int N = 4;
    localparam int D = 4;

    logic         clock;
    logic         reset;
    logic [N-1:0] botoes;
    logic         habilita;
    logic [N-1:0] jogada;
    logic         jogada_feita;
    logic         jogada_invalida;
    logic         ocupado;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] b;
        logic         h;
        logic [N-1:0] ej;
        logic         ef;
        logic         ei;
        logic         eo;
    } vec_t;

    vec_t tabela[$];

    // Reference model: tracks phases of the press by counting edges, not by state encoding.
    logic         mTracking, mCapture, mRelease;
    logic [N-1:0] mSample, mJog;
    int           mEdges, mZeroRun;
    logic         mF, mI;

    captura_jogada #(.N(N), .DEBOUNCE_CICLOS(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
        .jogada_invalida (jogada_invalida),
        .ocupado         (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void modelReset();
        mTracking = 1'b0;
        mCapture  = 1'b0;
        mRelease  = 1'b0;
        mSample   = '0;
        mJog      = '0;
        mEdges    = 0;
        mZeroRun  = 0;
        mF        = 1'b0;
        mI        = 1'b0;
    endfunction

    function automatic void modelEdge(input logic [N-1:0] b, input logic h);
        mF = 1'b0;
        mI = 1'b0;
        if (mCapture) begin
            mCapture = 1'b0;
            mRelease = 1'b1;
            mZeroRun = 0;
        end else if (mRelease) begin
            if (b == '0) begin
                mZeroRun++;
                if (mZeroRun == D) mRelease = 1'b0;
            end else begin
                mZeroRun = 0;
            end
        end else if (mTracking) begin
            if (!h || b == '0) begin
                mTracking = 1'b0;
            end else if (b != mSample) begin
                mSample = b;
                mEdges  = 0;
            end else begin
                mEdges++;
                if (mEdges == D) begin
                    mTracking = 1'b0;
                    mCapture  = 1'b1;
                    if ($countones(mSample) == 1) begin
                        mJog = mSample;
                        mF   = 1'b1;
                    end else begin
                        mI = 1'b1;
                    end
                end
            end
        end else if (h && b != '0) begin
            mTracking = 1'b1;
            mSample   = b;
            mEdges    = 0;
        end
    endfunction

    function automatic logic modelBusy();
        return mTracking | mCapture | mRelease;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] b, input logic h);
        botoes   = b;
        habilita = h;
        @(posedge clock);
        modelEdge(b, h);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] ej,
                               input logic ef, input logic ei, input logic eo);
        checks++;
        if (jogada !== ej) begin
            errors++;
            $display("[TB] FAIL %s jogada got=%b exp=%b t=%0t", name, jogada, ej, $time);
        end
        checks++;
        if (jogada_feita !== ef) begin
            errors++;
            $display("[TB] FAIL %s jogada_feita got=%b exp=%b t=%0t", name, jogada_feita, ef, $time);
        end
        checks++;
        if (jogada_invalida !== ei) begin
            errors++;
            $display("[TB] FAIL %s jogada_invalida got=%b exp=%b t=%0t", name, jogada_invalida, ei, $time);
        end
        checks++;
        if (ocupado !== eo) begin
            errors++;
            $display("[TB] FAIL %s ocupado got=%b exp=%b t=%0t", name, ocupado, eo, $time);
        end
    endtask

    // Asserts reset away from the clock edge, checks it acts immediately, holds it over an edge.
    task automatic applyReset();
        reset = 1'b1;
        #2;
        modelReset();
        checkOutput("reset_async", '0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        checkOutput("reset_held", '0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic addRows(input int n, input vec_t r);
        for (int k = 0; k < n; k++) tabela.push_back(r);
    endtask

    initial begin
        logic [N-1:0] curB;
        logic         curH;
        int           r;

        reset    = 1'b1;
        botoes   = '0;
        habilita = 1'b0;
        modelReset();
        #1;
        applyReset();

        // Idle with no buttons pressed.
        for (int i = 0; i < 20; i++) begin
            applyStimulus('0, 1'b1);
            checkOutput("idle", '0, 1'b0, 1'b0, 1'b0);
        end

        // Valid press 0100 held 10 cycles then released, then invalid 0110 held 8 cycles.
        addRows(4, '{4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1});
        addRows(1, '{4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1});
        addRows(5, '{4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1});
        addRows(3, '{4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1});
        addRows(2, '{4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0});
        addRows(4, '{4'b0110, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1});
        addRows(1, '{4'b0110, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b1});
        addRows(3, '{4'b0110, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1});
        addRows(3, '{4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b1});
        addRows(1, '{4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0});
        foreach (tabela[i]) begin
            applyStimulus(tabela[i].b, tabela[i].h);
            checkOutput($sformatf("table[%0d]", i), tabela[i].ej, tabela[i].ef,
                        tabela[i].ei, tabela[i].eo);
        end

        // Bounce on 0100 then a clean 0010 press.
        applyStimulus(4'b0100, 1'b1); checkOutput("bounce_a", 4'b0100, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0100, 1'b1); checkOutput("bounce_b", 4'b0100, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0000, 1'b1); checkOutput("bounce_gap", 4'b0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b1); checkOutput("bounce_e0", 4'b0100, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < D - 1; i++) begin
            applyStimulus(4'b0010, 1'b1); checkOutput("bounce_wait", 4'b0100, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(4'b0010, 1'b1); checkOutput("bounce_cap", 4'b0010, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) begin
            applyStimulus('0, 1'b1); checkOutput("bounce_rel", 4'b0010, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus('0, 1'b1); checkOutput("bounce_idle", 4'b0010, 1'b0, 1'b0, 1'b0);

        // Button held while habilita is low, then habilita rises.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1000, 1'b0); checkOutput("hab_low", 4'b0010, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(4'b1000, 1'b1); checkOutput("hab_e0", 4'b0010, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < D - 1; i++) begin
            applyStimulus(4'b1000, 1'b1); checkOutput("hab_wait", 4'b0010, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(4'b1000, 1'b1); checkOutput("hab_cap", 4'b1000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < D + 1; i++) applyStimulus('0, 1'b1);
        checkOutput("hab_idle", 4'b1000, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of debouncing, then a fresh capture.
        applyStimulus(4'b0001, 1'b1); checkOutput("rst_e0", 4'b1000, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'b0001, 1'b1); checkOutput("rst_e1", 4'b1000, 1'b0, 1'b0, 1'b1);
        applyReset();
        applyStimulus(4'b0001, 1'b1); checkOutput("rst_fresh_e0", '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < D - 1; i++) begin
            applyStimulus(4'b0001, 1'b1); checkOutput("rst_fresh_wait", '0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(4'b0001, 1'b1); checkOutput("rst_fresh_cap", 4'b0001, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < D + 1; i++) applyStimulus('0, 1'b1);
        checkOutput("rst_fresh_idle", 4'b0001, 1'b0, 1'b0, 1'b0);

        // Randomized stretches of stable button values against the model.
        curB = '0;
        curH = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                case ($urandom_range(0, 3))
                    0, 3:    curB = '0;
                    1:       curB = N'(1 << $urandom_range(0, N - 1));
                    default: curB = N'($urandom_range(0, (1 << N) - 1));
                endcase
            end
            curH = ($urandom_range(0, 99) < 90);
            if ($urandom_range(0, 299) == 0) applyReset();
            applyStimulus(curB, curH);
            checkOutput("random", mJog, mF, mI, modelBusy());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/captura_jogada.md
Name: captura_jogada

Overview:
- Upstream stage of the 4-bit play-select multiplexer in the Memory Challenge game datapath.
- Debounces the raw button vector, captures exactly one valid one-hot play, holds it on a registered 4-bit output, and emits single-cycle event pulses.
- Its `jogada` output drives the multiplexer data input for the player's play.
- Its `jogada_feita` pulse feeds the control unit's play-detected input.

Parameters:
- N, 4: number of buttons and width of `botoes` and `jogada`. The game instantiates it with 4.
- DEBOUNCE_CICLOS, 4: consecutive stable samples required. Legal range is ≥1. The game synthesises it with 50000; benches use 4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- botoes  in  N  raw button levels, 1 = pressed. Already synchronised upstream.
- habilita  in  1  allows a new capture to start.
- jogada  out  N  last valid captured play, registered.
- jogada_feita  out  1  one-cycle pulse when `jogada` is updated.
- jogada_invalida  out  1  one-cycle pulse when a stable press is not one-hot.
- ocupado  out  1  high whenever state ≠ OCIOSO.

Behaviour:
- Reset (asynchronous, active-high):
  - state = OCIOSO.
  - jogada = 0, amostra = 0, cnt = 0.
  - jogada_feita = 0, jogada_invalida = 0.
  - All outputs are at these values while reset is high, regardless of clock.
- Internal registers:
  - `amostra[N-1:0]`.
  - `cnt`, width $clog2(DEBOUNCE_CICLOS+1), saturating. No wrap-around is possible.
- All outputs are registered. `ocupado` is decoded from the state register.
- OCIOSO:
  - If habilita=1 and botoes≠0: amostra ← botoes, cnt ← 0, go to ESTABILIZA.
  - Otherwise stay.
- ESTABILIZA, evaluated in this priority order:
  1. habilita=0: go to OCIOSO (abort, no pulse).
  2. botoes=0: go to OCIOSO (glitch, no pulse).
  3. botoes≠amostra: amostra ← botoes, cnt ← 0, stay (restart).
  4. cnt=DEBOUNCE_CICLOS-1: go to CAPTURA. On this same edge:
     - If amostra is one-hot: jogada ← amostra, jogada_feita ← 1.
     - Otherwise: jogada_invalida ← 1, and jogada is kept.
  5. Otherwise: cnt ← cnt+1.
- CAPTURA (exactly one cycle):
  - Pulses are high during this cycle.
  - On the next edge: pulses ← 0, cnt ← 0, go to ESPERA_SOLTAR unconditionally.
  - habilita is ignored.
- ESPERA_SOLTAR:
  - If botoes≠0: cnt ← 0.
  - Else if cnt=DEBOUNCE_CICLOS-1: go to OCIOSO.
  - Else: cnt ← cnt+1.
  - habilita is ignored. A held button never produces a second capture.
- Latency: a press first sampled in OCIOSO at edge e0 and held stable produces `jogada_feita`=1 after edge e(DEBOUNCE_CICLOS), lasting 1 cycle.
- Release: all-zero must be held for DEBOUNCE_CICLOS edges before the block returns to OCIOSO.
- `jogada` changes only on a valid capture or on reset. It holds its value across invalid presses, aborts, and habilita=0.
- `jogada_feita` and `jogada_invalida` are mutually exclusive and never high in consecutive cycles.
- Reset asserted mid-operation (any state) returns the block to the reset values immediately.
- One-hot check: exactly one bit set. Zero bits is unreachable in CAPTURA.

Test Plan (DEBOUNCE_CICLOS=4):
- Reset then idle, botoes=0000 → jogada=0000, both pulses 0, ocupado=0 for 20 cycles.
- habilita=1, botoes=0100 held 10 cycles → jogada_feita=1 exactly one cycle, 4 edges after first sample. jogada=0100 from then on. ocupado returns to 0 four cycles after release.
- botoes=0100 for 2 cycles, then 0000, then 0010 held → no pulse for the 0100 bounce. Single jogada_feita with jogada=0010.
- botoes=0110 held 8 cycles → jogada_invalida one cycle. jogada keeps its prior 0010. No jogada_feita.
- habilita=0 with botoes=1000 held → ocupado stays 0, no pulses. Raising habilita while still held → capture after 4 more edges, jogada=1000.
- Reset asserted 2 cycles into ESTABILIZA → outputs zero immediately. After reset is released with botoes=0001 held → a fresh 4-edge debounce, then jogada=0001.
